// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and default sizes for the instruction fetch stage,
// the attached rom and their benches.
//   fetch_state_t        - fetch FSM state, 2-bit (IDLE=0, FETCH=1, HALT=2)
//   DEFAULT_DATA_WIDTH   - instruction word width
//   DEFAULT_N_WORDS      - program memory depth in words
package fetch_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_N_WORDS    = 128;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StHalt  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: owns the program counter, drives the combinational rom address
// and registers the returned word into a one-entry output stage handed to
// decode over valid/ready. Supports start, halt, branch redirect and PC wrap.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   start              - leave IDLE/HALT and begin fetching
//   halt_req           - stop issuing new fetches
//   redirect_valid     - load redirect_target into pc and flush the output
//   redirect_target    - new pc value
//   address            - rom address (combinational copy of pc)
//   rom_data           - rom data_out for address, same cycle
//   instr_valid/ready  - output handshake to decode
//   instr_data         - registered instruction word
//   instr_pc           - address instr_data was fetched from
//   fsm_state          - current state, for debug
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned N_WORDS    = DEFAULT_N_WORDS,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       halt_req,
    input  logic                       redirect_valid,
    input  logic [$clog2(N_WORDS)-1:0] redirect_target,
    output logic [$clog2(N_WORDS)-1:0] address,
    input  logic [DATA_WIDTH-1:0]      rom_data,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [DATA_WIDTH-1:0]      instr_data,
    output logic [$clog2(N_WORDS)-1:0] instr_pc,
    output logic [1:0]                 fsm_state
);

    localparam int unsigned AW = $clog2(N_WORDS);
    localparam logic [AW-1:0] RESET_ADDR = AW'(RESET_PC);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(N_WORDS - 1);

    fetch_state_t          state_q, state_d;
    logic [AW-1:0]         pc_q, pc_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [AW-1:0]         ipc_q, ipc_d;

    logic [AW-1:0] pc_inc;
    logic          load;
    logic          transfer;

    // Explicit wrap so non-power-of-two depths also return to 0.
    assign pc_inc   = (pc_q == LAST_ADDR) ? '0 : pc_q + AW'(1);
    assign load     = !valid_q || instr_ready;
    assign transfer = valid_q && instr_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        data_d  = data_q;
        ipc_d   = ipc_q;

        case (state_q)
            StIdle: begin
                if (transfer) valid_d = 1'b0;
                if (start) begin
                    state_d = StFetch;
                    pc_d    = RESET_ADDR;
                end
            end

            StFetch: begin
                if (redirect_valid) begin
                    // Flush wins even over an accepting decode; halt may ride along.
                    pc_d    = redirect_target;
                    valid_d = 1'b0;
                    if (halt_req) state_d = StHalt;
                end else if (halt_req) begin
                    state_d = StHalt;
                    if (transfer) valid_d = 1'b0;
                end else if (load) begin
                    data_d  = rom_data;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_inc;
                end
            end

            StHalt: begin
                // Pending word drains; no new loads.
                if (transfer) valid_d = 1'b1 ^ 1'b1;
                if (start) state_d = StFetch;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_ADDR;
            valid_q <= 1'b0;
            data_q  <= '0;
            ipc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ipc_q   <= ipc_d;
        end
    end

    assign address     = pc_q;
    assign instr_valid = valid_q;
    assign instr_data  = data_q;
    assign instr_pc    = ipc_q;
    assign fsm_state   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch. A behavioural rom returns
// 32'h1000_0000 + address. Inputs change #1 after a rising edge; outputs are
// sampled at the same point, well away from the next edge.
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam int unsigned DW = DEFAULT_DATA_WIDTH;
    localparam int unsigned NW = DEFAULT_N_WORDS;
    localparam int unsigned AW = $clog2(NW);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          halt_req;
    logic          redirect_valid;
    logic [AW-1:0] redirect_target;
    logic [AW-1:0] address;
    logic [DW-1:0] rom_data;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic [1:0]    fsm_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign rom_data = 32'h1000_0000 + DW'(address);

    instr_fetch #(
        .DATA_WIDTH(DW),
        .N_WORDS   (NW),
        .RESET_PC  (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .halt_req       (halt_req),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .address        (address),
        .rom_data       (rom_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .fsm_state      (fsm_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect a valid word fetched from pc p.
    task automatic check_word(input string tag, input int unsigned p);
        check({tag, ".valid"}, 64'(instr_valid), 64'd1);
        check({tag, ".pc"}, 64'(instr_pc), 64'(p));
        check({tag, ".data"}, 64'(instr_data), 64'(32'h1000_0000 + p));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
        redirect_target = '0; instr_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst.state", 64'(fsm_state), 64'd0);
        check("rst.valid", 64'(instr_valid), 64'd0);
        check("rst.data", 64'(instr_data), 64'd0);
        check("rst.ipc", 64'(instr_pc), 64'd0);
        check("rst.addr", 64'(address), 64'd0);

        // Start: FETCH right away, first word one edge later.
        start = 1'b1;
        step();
        start = 1'b0;
        check("start.state", 64'(fsm_state), 64'd1);
        check("start.valid", 64'(instr_valid), 64'd0);
        check("start.addr", 64'(address), 64'd0);
        step();
        check_word("w0", 0);
        for (int i = 1; i <= 5; i++) begin
            step();
            check_word("stream", i);
        end

        // Stall three cycles on word 5, then word 6 follows.
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_word("stall", 5);
        end
        instr_ready = 1'b1;
        step();
        check_word("unstall", 6);

        // Redirect near end of memory: one bubble then 126,127,0,1.
        redirect_valid = 1'b1; redirect_target = AW'(126);
        step();
        redirect_valid = 1'b0;
        check("wrap.bubble", 64'(instr_valid), 64'd0);
        check("wrap.addr", 64'(address), 64'd126);
        step(); check_word("wrap126", 126);
        step(); check_word("wrap127", 127);
        step(); check_word("wrap0", 0);
        step(); check_word("wrap1", 1);

        // Reach pc 10, stall there, redirect to 40 while stalled.
        redirect_valid = 1'b1; redirect_target = AW'(10);
        step();
        redirect_valid = 1'b0;
        step();
        check_word("at10", 10);
        instr_ready = 1'b0;
        step();
        check_word("stall10", 10);
        redirect_valid = 1'b1; redirect_target = AW'(40);
        step();
        redirect_valid = 1'b0;
        check("redir40.flush", 64'(instr_valid), 64'd0);
        check("redir40.addr", 64'(address), 64'd40);
        instr_ready = 1'b1;
        step();
        check_word("redir40", 40);

        // Halt with a held word: retained, drains on ready, resume at pc 41.
        instr_ready = 1'b0;
        step();
        check_word("pre_halt", 40);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("halt.state", 64'(fsm_state), 64'd2);
        check_word("halt.keep", 40);
        step();
        check_word("halt.keep2", 40);
        instr_ready = 1'b1;
        step();
        check("halt.drain", 64'(instr_valid), 64'd0);
        check("halt.state2", 64'(fsm_state), 64'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        check("resume.state", 64'(fsm_state), 64'd1);
        check("resume.valid", 64'(instr_valid), 64'd0);
        step();
        check_word("resume41", 41);

        // Redirect + halt together, then start: first word is pc 20.
        redirect_valid = 1'b1; redirect_target = AW'(20); halt_req = 1'b1;
        step();
        redirect_valid = 1'b0; halt_req = 1'b0;
        check("rh.state", 64'(fsm_state), 64'd2);
        check("rh.valid", 64'(instr_valid), 64'd0);
        check("rh.addr", 64'(address), 64'd20);
        step();
        check("rh.noload", 64'(instr_valid), 64'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check_word("rh20", 20);
        step();
        check_word("rh21", 21);

        // Reset mid-stream.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst.state", 64'(fsm_state), 64'd0);
        check("mrst.valid", 64'(instr_valid), 64'd0);
        check("mrst.data", 64'(instr_data), 64'd0);
        check("mrst.ipc", 64'(instr_pc), 64'd0);
        check("mrst.addr", 64'(address), 64'd0);

        // IDLE ignores redirect and halt.
        redirect_valid = 1'b1; redirect_target = AW'(77); halt_req = 1'b1;
        step();
        redirect_valid = 1'b0; halt_req = 1'b0;
        check("idle.state", 64'(fsm_state), 64'd0);
        check("idle.addr", 64'(address), 64'd0);
        check("idle.valid", 64'(instr_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the combinational `rom` program memory. It owns the program counter and drives the ROM address. It captures the returned word into a one-entry output register and hands it to decode over a valid/ready handshake. It supports start, halt and branch redirect, and PC wrap-around at the end of memory.

## Interface
- `DATA_WIDTH`, 32, instruction word width; must match the attached `rom`.
- `N_WORDS`, 128, ROM depth in words; the address width is `$clog2(N_WORDS)`.
- `RESET_PC`, 0, first fetch address after `start` from IDLE; must be less than `N_WORDS`.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: leave IDLE or HALT and begin fetching.
- `halt_req` in 1: stop issuing new fetches.
- `redirect_valid` in 1: load a new PC and flush the output register.
- `redirect_target` in `$clog2(N_WORDS)`: new PC value.
- `address` out `$clog2(N_WORDS)`: ROM address; combinational copy of `pc`.
- `rom_data` in `DATA_WIDTH`: ROM `data_out`, valid in the same cycle as `address`.
- `instr_valid` out 1: `instr_data` and `instr_pc` hold a fetched word.
- `instr_ready` in 1: decode accepts the word this cycle.
- `instr_data` out `DATA_WIDTH`: registered instruction word.
- `instr_pc` out `$clog2(N_WORDS)`: address the word was fetched from.
- `fsm_state` out 2: current state, for debug.

## Operation
- States: IDLE=0, FETCH=1, HALT=2. Encoding 3 is illegal and goes to IDLE on the next edge.
- Reset values: state IDLE, `pc`=`RESET_PC`, `instr_valid`=0, `instr_data`=0, `instr_pc`=0.
- IDLE:
  - `start` moves to FETCH with `pc`=`RESET_PC`.
  - `halt_req` and `redirect_valid` are ignored.
- FETCH:
  - `load` = `!instr_valid || instr_ready`.
  - On `load`: `instr_data`<=`rom_data`, `instr_pc`<=`pc`, `instr_valid`<=1, `pc`<=`pc+1`.
  - Wrap-around: `pc`=`N_WORDS-1` increments to 0.
  - Without `load`: `pc`, `instr_data` and `instr_pc` hold, and `instr_valid` stays 1. Stall is lossless.
- `redirect_valid` in FETCH has highest priority:
  - `pc`<=`redirect_target` and `instr_valid`<=0, regardless of `instr_ready`.
  - No load happens that cycle; the word then in the output register is discarded even if accepted that cycle.
- `halt_req` in FETCH:
  - Moves to HALT; no load that cycle.
  - A pending `instr_valid`=1 word stays until decode accepts it, then `instr_valid` clears.
- Simultaneous `redirect_valid` and `halt_req`: both take effect. `pc`<=target, flush, state HALT.
- HALT:
  - No loads.
  - `start` returns to FETCH with `pc` unchanged.
  - `redirect_valid` is ignored.
- `start` while in FETCH is ignored.
- Reset mid-operation (any state, any handshake phase) restores all reset values on the next edge; an in-flight word is dropped.
- `redirect_target` must be less than `N_WORDS`; other values are out of contract.

## Timing
- `address` follows `pc` combinationally, with zero latency to the ROM.
- `start` sampled at edge E0 gives FETCH at E0. At E1, `instr_valid`=1 with the word at `RESET_PC`.
- Throughput: one word per cycle while `instr_ready`=1.
- Redirect sampled at edge R: `instr_valid`=0 after R, and the target word is valid after R+1. The bubble is one cycle.
- Handshake: a transfer happens on an edge where `instr_valid` and `instr_ready` are both 1. `instr_valid` never drops without a transfer, except on redirect or reset.

## Structure
- `fetch_pkg` holds:
  - the `fetch_state_t` enum (IDLE, FETCH, HALT), 2-bit;
  - the `DATA_WIDTH` and `N_WORDS` defaults as shared constants for `rom`, `instr_fetch` and the benches.
- Single module with no sub-module. The PC increment-with-wrap lives inline.
- `rom` is instantiated beside `instr_fetch` at integration level, not inside it.

## Test plan
- Reset, then `start`, with `instr_ready`=1 and the ROM loaded with word i = 32'h1000_0000+i:
  - words 0,1,2,… are delivered on consecutive cycles;
  - `instr_pc` = 0,1,2,….
- Stall: drop `instr_ready` for 3 cycles while holding the word at pc 5:
  - `instr_data`=32'h1000_0005 is held and `instr_valid`=1 throughout;
  - pc 6 follows on the first ready cycle.
- Wrap: `redirect_target`=126, then free run:
  - sequence 126, 127, 0, 1;
  - exactly one bubble after the redirect.
- Redirect while stalled at pc 10 to target 40:
  - the word at pc 10 is never transferred;
  - the next valid word is 32'h1000_0028.
- Halt with `instr_valid`=1 and `instr_ready`=0:
  - state goes to HALT and the word is retained;
  - after ready, `instr_valid`=0;
  - `start` resumes at the following pc.
- Simultaneous `redirect_valid` (target 20) and `halt_req`, then `start`:
  - first delivered word is pc 20.
- Reset during mid-stream output:
  - all outputs return to reset values;
  - state reads IDLE.
